i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h42, giving the 7-bit address this target answers to.
REQ-002 SHALL have parameter SYS_CLOCK_FREQ_HZ, default 100_000_000, giving the i_clk frequency; it must be at least 20x the bus SCL frequency.
REQ-003 SHALL have port i_clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_tx_data, input, 8 bits: the byte returned to the master on reads.
REQ-006 SHALL have port i_rx_ready, input, 1 bit: when high, the next received data byte is ACKed; when low, it is NACKed.
REQ-007 SHALL have port o_rx_data, output, 8 bits: the last data byte received.
REQ-008 SHALL have port o_rx_data_valid, output, 1 bit: a one-cycle pulse marking o_rx_data as new.
REQ-009 SHALL have port o_tx_data_needed, output, 1 bit: a one-cycle pulse requesting the next read byte.
REQ-010 SHALL have port o_status_reg, output, 5 bits: [BUSY, RW_MODE, STOP_DET, TX_NACK, GEN_CALL].
REQ-011 SHALL have port io_sda, inout, 1 bit: open-drain; driven 1'b0 or released to 1'bz, never driven high.
REQ-012 SHALL have port io_scl, inout, 1 bit: permanently 1'bz; the block only observes SCL.

Function
REQ-013 SHALL pass SDA and SCL through a 2-flop synchronizer, then a 3-sample agreement filter; a filtered value changes only after 3 equal consecutive samples.
REQ-014 SHALL detect START and repeated START as filtered SDA falling while SCL is high, and STOP as filtered SDA rising while SCL is high.
REQ-015 SHALL sample SDA on each filtered SCL rising edge, and change its SDA drive on the cycle after a filtered SCL falling edge.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK and WAIT_STOP.
REQ-017 SHALL, on START or repeated START from any state, release SDA, clear the bit counter and enter ADDR.
REQ-018 SHALL, on STOP from any state, release SDA, pulse STOP_DET for one cycle, clear BUSY and enter IDLE.
REQ-019 SHALL shift 8 bits MSB-first in ADDR; if bits [7:1] equal SLAVE_ADDR, it sets BUSY, sets RW_MODE to bit 0, and enters ADDR_ACK (drives SDA low for the 9th clock); otherwise it enters WAIT_STOP with SDA released.
REQ-020 SHALL, after ADDR_ACK with RW_MODE=0, enter RX_BYTE; after 8 bits it updates o_rx_data and pulses o_rx_data_valid on the cycle the 8th bit is sampled.
REQ-021 SHALL, in RX_ACK, drive SDA low if i_rx_ready was high at the 8th-bit sample, else release SDA and go to WAIT_STOP after the 9th clock; an ACK returns to RX_BYTE.
REQ-022 SHALL, with RW_MODE=1, pulse o_tx_data_needed on the SCL falling edge ending ADDR_ACK, and capture i_tx_data exactly one cycle after the pulse.
REQ-023 SHALL shift the captured byte out MSB-first in TX_BYTE, driving low for 0 and releasing for 1, then release SDA for TX_ACK.
REQ-024 SHALL, in TX_ACK, treat sampled SDA=0 as ACK: it pulses o_tx_data_needed and returns to TX_BYTE.
REQ-025 SHALL, in TX_ACK, treat sampled SDA=1 as NACK: it pulses TX_NACK for one cycle and enters WAIT_STOP.
REQ-026 SHALL ignore all SCL edges in IDLE and WAIT_STOP, which are left only by START/STOP.
REQ-027 SHALL use a 4-bit bit counter that wraps to 0 at each ACK slot; byte count is unbounded.

Reset
REQ-028 SHALL, while i_rst is high, force state IDLE, SDA released, o_rx_data=8'h00, o_rx_data_valid=0, o_tx_data_needed=0, o_status_reg=5'b0, and the synchronizers and filters to 1.
REQ-029 SHALL, if reset is asserted mid-transfer, release SDA within one cycle and ignore the bus until the next START.

Configuration
REQ-030 SHALL, with macro I2C_SLAVE_GENERAL_CALL_EN defined, ACK address byte 8'h00 (general call, write), set GEN_CALL=1 until STOP, and receive bytes per REQ-020 and REQ-021.
REQ-031 SHALL, without I2C_SLAVE_GENERAL_CALL_EN, treat address 8'h00 as a mismatch (NACK, WAIT_STOP), with GEN_CALL tied to 0.

Verification
REQ-032 Write 0x84, 0xA5, 0x3C with i_rx_ready=1 -> three ACKs, o_rx_data_valid pulses with 0xA5 then 0x3C, STOP_DET pulse, BUSY=0.
REQ-033 Read 0x85 with i_tx_data=0x5A then 0xC3, master ACKs byte 1 and NACKs byte 2 -> bus bits 0x5A, 0xC3, two o_tx_data_needed pulses, one TX_NACK pulse.
REQ-034 Address 0x90 (mismatch) followed by 2 bytes -> SDA never driven low, no rx/tx pulses, BUSY stays 0.
REQ-035 Write 0x84, 0x11 with i_rx_ready=0 -> address ACKed, data NACKed, WAIT_STOP until STOP.
REQ-036 Write 0x84, 0x22, then repeated START with 0x85 -> read path entered, RW_MODE=1, tx byte shifted out; i_rst asserted mid-read -> SDA released next cycle.
REQ-037 Address 0x00, data 0x06 -> ACK and GEN_CALL=1 when the macro is defined; NACK and no o_rx_data_valid when it is not.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target: filtered SDA/SCL front end, START/STOP detection and a byte-level
// read/write FSM. Define I2C_SLAVE_GENERAL_CALL_EN to also ACK the general-call address.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR        = 7'h42,
    parameter int         SYS_CLOCK_FREQ_HZ = 100_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_rx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_data_valid,
    output logic       o_tx_data_needed,
    output logic [4:0] o_status_reg,
    inout  wire        io_sda,
    inout  wire        io_scl
);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    // The filter needs several i_clk samples per SCL phase; 2 MHz covers a 100 kHz bus.
    if (SYS_CLOCK_FREQ_HZ < 2_000_000) begin : g_freq_chk
        $error("i2c_slave: SYS_CLOCK_FREQ_HZ too low for the SCL filter");
    end

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    logic [1:0] scl_s_q, scl_s_d, sda_s_q, sda_s_d;
    logic [2:0] scl_h_q, scl_h_d, sda_h_q, sda_h_d;
    logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic       scl_fd_q, scl_fd_d, sda_fd_q, sda_fd_d;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] sh_q, sh_d;
    logic [6:0] tx_sh_q, tx_sh_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_vld_q, rx_vld_d;
    logic       tx_need_q, tx_need_d;
    logic       load_q, load_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d, rw_q, rw_d;
    logic       stop_det_q, stop_det_d, tx_nack_q, tx_nack_d;
    logic       gen_call_q, gen_call_d;

    logic       start, stop, scl_rise, scl_fall;
    logic [7:0] shift_in;

    always_comb begin
        scl_s_d  = {scl_s_q[0], io_scl};
        sda_s_d  = {sda_s_q[0], io_sda};
        scl_h_d  = {scl_h_q[1:0], scl_s_q[1]};
        sda_h_d  = {sda_h_q[1:0], sda_s_q[1]};
        scl_f_d  = scl_f_q;
        sda_f_d  = sda_f_q;
        if (&scl_h_q)       scl_f_d = 1'b1;
        else if (~|scl_h_q) scl_f_d = 1'b0;
        if (&sda_h_q)       sda_f_d = 1'b1;
        else if (~|sda_h_q) sda_f_d = 1'b0;
        scl_fd_d = scl_f_q;
        sda_fd_d = sda_f_q;
    end

    assign scl_rise = scl_f_q & ~scl_fd_q;
    assign scl_fall = ~scl_f_q & scl_fd_q;
    assign start    = scl_f_q & scl_fd_q & sda_fd_q & ~sda_f_q;
    assign stop     = scl_f_q & scl_fd_q & ~sda_fd_q & sda_f_q;
    assign shift_in = {sh_q, sda_f_q};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        tx_sh_d    = tx_sh_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_vld_d   = 1'b0;
        tx_need_d  = 1'b0;
        load_d     = tx_need_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        stop_det_d = 1'b0;
        tx_nack_d  = 1'b0;
        gen_call_d = gen_call_q;

        if (start) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ADDR;
        end else if (stop) begin
            sda_oe_d   = 1'b0;
            stop_det_d = 1'b1;
            busy_d     = 1'b0;
            gen_call_d = 1'b0;
            state_d    = IDLE;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    sh_d      = shift_in[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (shift_in[7:1] == SLAVE_ADDR) begin
                            busy_d  = 1'b1;
                            rw_d    = shift_in[0];
                            state_d = ADDR_ACK;
                        end else if (GC_EN && shift_in == 8'h00) begin
                            busy_d     = 1'b1;
                            rw_d       = 1'b0;
                            gen_call_d = 1'b1;
                            state_d    = ADDR_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                // bit_cnt==8 marks the fall opening the ACK slot, 0 the fall closing it
                ADDR_ACK: begin
                    if (scl_fall && bit_cnt_q == 4'd8) sda_oe_d = 1'b1;
                    if (scl_rise) bit_cnt_d = 4'd0;
                    if (scl_fall && bit_cnt_q == 4'd0) begin
                        sda_oe_d = 1'b0;
                        if (rw_q) begin
                            tx_need_d = 1'b1;
                            state_d   = TX_BYTE;
                        end else begin
                            state_d = RX_BYTE;
                        end
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    sh_d      = shift_in[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        rx_data_d = shift_in;
                        rx_vld_d  = 1'b1;
                        ack_d     = i_rx_ready;
                        state_d   = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall && bit_cnt_q == 4'd8) sda_oe_d = ack_q;
                    if (scl_rise) begin
                        bit_cnt_d = 4'd0;
                        if (!ack_q) state_d = WAIT_STOP;
                    end
                    if (scl_fall && bit_cnt_q == 4'd0) begin
                        sda_oe_d = 1'b0;
                        state_d  = RX_BYTE;
                    end
                end
                // First bit goes out once the requested byte has been captured
                TX_BYTE: begin
                    if (load_q) begin
                        tx_sh_d  = i_tx_data[6:0];
                        sda_oe_d = ~i_tx_data[7];
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = TX_ACK;
                        end else begin
                            sda_oe_d = ~tx_sh_q[6];
                            tx_sh_d  = {tx_sh_q[5:0], 1'b0};
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = 4'd0;
                        if (sda_f_q) begin
                            tx_nack_d = 1'b1;
                            state_d   = WAIT_STOP;
                        end
                    end
                    if (scl_fall && bit_cnt_q == 4'd0) begin
                        tx_need_d = 1'b1;
                        state_d   = TX_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_s_q    <= 2'b11;
            sda_s_q    <= 2'b11;
            scl_h_q    <= 3'b111;
            sda_h_q    <= 3'b111;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_fd_q   <= 1'b1;
            sda_fd_q   <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            sh_q       <= 7'd0;
            tx_sh_q    <= 7'd0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_vld_q   <= 1'b0;
            tx_need_q  <= 1'b0;
            load_q     <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            stop_det_q <= 1'b0;
            tx_nack_q  <= 1'b0;
            gen_call_q <= 1'b0;
        end else begin
            scl_s_q    <= scl_s_d;
            sda_s_q    <= sda_s_d;
            scl_h_q    <= scl_h_d;
            sda_h_q    <= sda_h_d;
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_fd_q   <= scl_fd_d;
            sda_fd_q   <= sda_fd_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            tx_sh_q    <= tx_sh_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_vld_q   <= rx_vld_d;
            tx_need_q  <= tx_need_d;
            load_q     <= load_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            stop_det_q <= stop_det_d;
            tx_nack_q  <= tx_nack_d;
            gen_call_q <= gen_call_d;
        end
    end

    assign io_sda           = sda_oe_q ? 1'b0 : 1'bz;
    assign io_scl           = 1'bz;
    assign o_rx_data        = rx_data_q;
    assign o_rx_data_valid  = rx_vld_q;
    assign o_tx_data_needed = tx_need_q;
    assign o_status_reg     = {busy_q, rw_q, stop_det_q, tx_nack_q, gen_call_q & GC_EN};

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged bus master, vector table of write transfers,
// hand-written read/repeated-START/reset sequences, and randomized transfers.
module tb_i2c_slave;
    localparam int H = 20;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]      addr;
        logic [2:0][7:0] d;
        logic [1:0]      n;
        logic [2:0]      rdy;
        logic            aack;
        logic            gc;
        logic [2:0]      dack;
        logic [1:0]      nval;
    } wvec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data;
    logic [7:0] o_rx_data;
    logic       o_rx_data_valid, o_tx_data_needed;
    logic [4:0] o_status_reg;
    logic       m_sda = 1'b1, m_scl = 1'b1;
    wire        sda_w, scl_w;

    assign sda_w = m_sda ? 1'bz : 1'b0;
    assign scl_w = m_scl ? 1'bz : 1'b0;
    pullup pu_sda (sda_w);
    pullup pu_scl (scl_w);

    always #5 clk = ~clk;

    i2c_slave dut (
        .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data), .i_rx_ready(rx_ready),
        .o_rx_data(o_rx_data), .o_rx_data_valid(o_rx_data_valid),
        .o_tx_data_needed(o_tx_data_needed), .o_status_reg(o_status_reg),
        .io_sda(sda_w), .io_scl(scl_w)
    );

    int total = 0, bad = 0;
    int n_valid = 0, n_txneed = 0, n_stop = 0, n_nack = 0, n_dlow = 0, n_txfed = 0;
    logic [7:0] rx_log[$];
    logic [2:0] tpipe = 3'b000;
    logic [7:0] tx_buf [4];
    int tx_base = 0;
    int tx_k;

    // Pulse counters count cycles high, so a stretched pulse shows up as an extra event
    always @(negedge clk) begin
        if (o_rx_data_valid === 1'b1) begin n_valid++; rx_log.push_back(o_rx_data); end
        if (o_tx_data_needed === 1'b1) n_txneed++;
        if (o_status_reg[2] === 1'b1) n_stop++;
        if (o_status_reg[1] === 1'b1) n_nack++;
        if (m_sda && sda_w === 1'b0) n_dlow++;
        if (tpipe[2]) n_txfed++;
        tpipe = {tpipe[1:0], o_tx_data_needed === 1'b1};
    end

    // Next read byte is presented a few cycles after each request pulse
    always_comb begin
        tx_k = n_txfed - tx_base;
        if (tx_k < 0) tx_k = 0;
        if (tx_k > 3) tx_k = 3;
        tx_data = tx_buf[tx_k];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_x(input logic b, output logic s);
        m_sda = b; wt(H); m_scl = 1'b1; wt(H); s = sda_w; m_scl = 1'b0; wt(4);
    endtask

    task automatic start_c();
        m_sda = 1'b1; wt(H); m_scl = 1'b1; wt(H); m_sda = 1'b0; wt(H); m_scl = 1'b0; wt(4);
    endtask

    task automatic stop_c();
        m_sda = 1'b0; wt(H); m_scl = 1'b1; wt(H); m_sda = 1'b1; wt(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(b[i], s);
        bit_x(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic mack);
        logic s;
        for (int i = 7; i >= 0; i--) begin bit_x(1'b1, s); b[i] = s; end
        bit_x(~mack, s);
    endtask

    function automatic wvec_t mk(input logic [7:0] a, input logic [23:0] d, input logic [1:0] n,
                                 input logic [2:0] rdy, input logic aack, input logic gc,
                                 input logic [2:0] dack, input logic [1:0] nval);
        wvec_t v;
        v.addr = a; v.d = d; v.n = n; v.rdy = rdy;
        v.aack = aack; v.gc = gc; v.dack = dack; v.nval = nval;
        return v;
    endfunction

    // Reference: the address is claimed on a match (or general call), every byte
    // received while engaged is reported, and the first unready byte disengages.
    function automatic wvec_t model_w(input logic [7:0] a, input logic [23:0] d,
                                      input logic [1:0] n, input logic [2:0] rdy);
        wvec_t v;
        logic  act;
        v.addr = a; v.d = d; v.n = n; v.rdy = rdy;
        v.aack = (a[7:1] == 7'h42) || (GC && a == 8'h00);
        v.gc   = GC && a == 8'h00;
        v.dack = 3'b000; v.nval = 2'd0;
        act    = v.aack;
        for (int i = 0; i < 3; i++) begin
            if (i < int'(n) && act) begin
                v.nval    = v.nval + 2'd1;
                v.dack[i] = rdy[i];
                act       = rdy[i];
            end
        end
        return v;
    endfunction

    task automatic run_write(input wvec_t v);
        logic a;
        logic [2:0] dk;
        int bv, bs, bd, rb;
        bv = n_valid; bs = n_stop; bd = n_dlow; rb = rx_log.size();
        dk = 3'b000;
        start_c();
        write_byte(v.addr, a);
        chk("addr_ack", a, v.aack);
        chk("busy", o_status_reg[4], v.aack);
        chk("gen_call", o_status_reg[0], v.gc);
        for (int i = 0; i < 3; i++) begin
            if (i < int'(v.n)) begin
                rx_ready = v.rdy[i];
                write_byte(v.d[i], a);
                dk[i] = a;
            end
        end
        stop_c(); wt(8);
        chk("data_ack", dk, v.dack);
        chk("n_valid", n_valid - bv, v.nval);
        for (int i = 0; i < int'(v.nval); i++)
            chk("rx_byte", (rb + i < rx_log.size()) ? rx_log[rb + i] : 8'hxx, v.d[i]);
        chk("stop_det", n_stop - bs, 1);
        chk("busy_end", o_status_reg[4], 1'b0);
        if (!v.aack) chk("sda_low", n_dlow - bd, 0);
    endtask

    task automatic run_read(input logic [23:0] bytes, input int n);
        logic a;
        logic [7:0] got;
        int bt, bn, bs;
        for (int i = 0; i < 3; i++) tx_buf[i] = bytes[i*8 +: 8];
        tx_buf[3] = 8'hEE;
        tx_base = n_txfed;
        bt = n_txneed; bn = n_nack; bs = n_stop;
        start_c();
        write_byte(8'h85, a);
        chk("rd_addr_ack", a, 1'b1);
        chk("rw_mode", o_status_reg[4:3], 2'b11);
        for (int i = 0; i < n; i++) begin
            read_byte(got, i < n - 1);
            chk("rd_byte", got, bytes[i*8 +: 8]);
        end
        stop_c(); wt(8);
        chk("tx_needed", n_txneed - bt, n);
        chk("tx_nack", n_nack - bn, 1);
        chk("rd_stop_det", n_stop - bs, 1);
        chk("rd_busy_end", o_status_reg[4], 1'b0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wvec_t tbl [5];
        wvec_t v;
        logic a, s;
        logic [31:0] r;
        logic [23:0] rd;
        int bt, bv, bd;

        for (int i = 0; i < 4; i++) tx_buf[i] = 8'h00;
        tbl[0] = mk(8'h84, 24'h003CA5, 2'd2, 3'b111, 1'b1, 1'b0, 3'b011, 2'd2);
        tbl[1] = mk(8'h90, 24'h003412, 2'd2, 3'b111, 1'b0, 1'b0, 3'b000, 2'd0);
        tbl[2] = mk(8'h84, 24'h000011, 2'd1, 3'b000, 1'b1, 1'b0, 3'b000, 2'd1);
        tbl[3] = mk(8'h00, 24'h000006, 2'd1, 3'b111, GC, GC, {2'b00, GC}, {1'b0, GC});
        tbl[4] = mk(8'h84, 24'h8000FF, 2'd3, 3'b101, 1'b1, 1'b0, 3'b001, 2'd2);

        wt(5);
        chk("rst_rx_data", o_rx_data, 8'h00);
        chk("rst_rx_valid", o_rx_data_valid, 1'b0);
        chk("rst_tx_needed", o_tx_data_needed, 1'b0);
        chk("rst_status", o_status_reg, 5'b0);
        chk("rst_sda", sda_w, 1'b1);
        @(negedge clk) rst = 1'b0;
        wt(10);

        for (int i = 0; i < 5; i++) run_write(tbl[i]);

        run_read(24'h00C35A, 2);

        // Write, repeated START into a read, then reset while the target drives SDA
        tx_buf[0] = 8'h00; tx_base = n_txfed;
        bv = n_valid; bt = n_txneed;
        rx_ready = 1'b1;
        start_c();
        write_byte(8'h84, a); chk("rs_addr_ack", a, 1'b1);
        write_byte(8'h22, a); chk("rs_data_ack", a, 1'b1);
        chk("rs_valid", n_valid - bv, 1);
        chk("rs_rx_data", o_rx_data, 8'h22);
        start_c();
        write_byte(8'h85, a); chk("rs_rd_ack", a, 1'b1);
        chk("rs_rw_mode", o_status_reg[3], 1'b1);
        for (int i = 0; i < 4; i++) begin bit_x(1'b1, s); chk("rs_tx_bit", s, 1'b0); end
        wt(10);
        chk("rs_sda_driven", sda_w, 1'b0);
        chk("rs_tx_needed", n_txneed - bt, 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_sda_release", sda_w, 1'b1);
        wt(2);
        chk("rst_mid_status", o_status_reg, 5'b0);
        chk("rst_mid_rx_data", o_rx_data, 8'h00);
        @(negedge clk) rst = 1'b0;
        bv = n_valid; bt = n_txneed; bd = n_dlow;
        for (int i = 0; i < 5; i++) bit_x(1'b1, s);
        stop_c(); wt(8);
        chk("post_rst_quiet", {n_valid - bv, n_txneed - bt, n_dlow - bd}, 0);
        chk("post_rst_busy", o_status_reg[4], 1'b0);

        for (int k = 0; k < 6; k++) begin
            r = $urandom;
            case (r[1:0])
                2'd0:    v.addr = 8'h84;
                2'd1:    v.addr = 8'h00;
                default: v.addr = {r[8:2], 1'b0};
            endcase
            rd = $urandom;
            r  = $urandom;
            v  = model_w(v.addr, rd, 2'(1 + (r % 3)), r[4:2]);
            run_write(v);
        end

        for (int k = 0; k < 4; k++) begin
            rd = $urandom;
            run_read(rd, 1 + ($urandom % 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
